cache_rd_arbiter: RTL and testbench

Two-requester arbiter and sequencer that shares a single AXI-side refill read port between the instruction cache and the data cache. Each cache sees its own dedicated rd_req/rd_rdy/ret_valid/ret_data port. The arbiter grants one miss at a time using round-robin priority, forwards the line address to the bus interface, and routes the returned 128-bit line back to the owning cache. It sits between the two caches' MISS/REFILL logic and the AXI bridge.

---
 rtl/cache_rd_arbiter.sv | 160 ++++++++++++++++
 tb/tb_cache_rd_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_rd_arbiter.sv
// cache_rd_arbiter
//   Shares one refill read port towards the AXI bridge between the
//   instruction cache and the data cache. One miss is in flight at a time.
//   Simultaneous requests are resolved round-robin. The returned line is
//   buffered for one cycle and handed back to the cache that owns the
//   transaction.
//
// Ports
//   clk            clock, all state on rising edge
//   resetn         asynchronous reset, ACTIVE HIGH (1 = reset)
//   i_rd_req/addr  icache refill request, held until i_rd_rdy
//   i_rd_rdy       icache request accepted (combinational pulse)
//   i_ret_valid    icache line returned (registered pulse)
//   i_ret_data     returned line, qualified by i_ret_valid
//   d_*            same set for the dcache
//   m_rd_req/addr  registered request towards the AXI bridge
//   m_rd_rdy       bridge accepts the request this cycle
//   m_ret_valid    bridge returns a line (pulse)
//   m_ret_data     returned line
//   busy           registered, high whenever the FSM is not IDLE
//   spurious_ret   sticky flag: m_ret_valid seen outside WAIT

module cache_rd_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 128,
    parameter logic        PRIO_D = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              i_rd_rdy,
    output logic              i_ret_valid,
    output logic [LINE_W-1:0] i_ret_data,

    input  logic              d_rd_req,
    input  logic [ADDR_W-1:0] d_rd_addr,
    output logic              d_rd_rdy,
    output logic              d_ret_valid,
    output logic [LINE_W-1:0] d_ret_data,

    output logic              m_rd_req,
    output logic [ADDR_W-1:0] m_rd_addr,
    input  logic              m_rd_rdy,
    input  logic              m_ret_valid,
    input  logic [LINE_W-1:0] m_ret_data,

    output logic              busy,
    output logic              spurious_ret
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // owner / last_grant encoding: 1 = dcache, 0 = icache
    logic              owner;
    logic              owner_nxt;
    logic              last_grant;
    logic [ADDR_W-1:0] addr_nxt;
    logic [LINE_W-1:0] ret_buf;
    logic              grant_d;
    logic              ret_take;

    // Under contention the side that did not win last time is granted.
    assign grant_d  = d_rd_req && (!i_rd_req || !last_grant);
    assign ret_take = (state == WAIT) && m_ret_valid;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        addr_nxt  = m_rd_addr;
        case (state)
            IDLE: begin
                if (i_rd_req || d_rd_req) begin
                    state_nxt = REQ;
                    owner_nxt = grant_d;
                    addr_nxt  = grant_d ? d_rd_addr : i_rd_addr;
                end
            end
            REQ: begin
                if (m_rd_rdy) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (m_ret_valid) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state <= IDLE;
            owner <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    // Registered outputs are derived from the next state so that they line
    // up with the state they describe rather than lagging it by a cycle.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            m_rd_req    <= 1'b0;
            m_rd_addr   <= '0;
            busy        <= 1'b0;
            i_ret_valid <= 1'b0;
            d_ret_valid <= 1'b0;
        end else begin
            m_rd_req    <= (state_nxt == REQ);
            m_rd_addr   <= addr_nxt;
            busy        <= (state_nxt != IDLE);
            i_ret_valid <= (state_nxt == RESP) && !owner_nxt;
            d_ret_valid <= (state_nxt == RESP) &&  owner_nxt;
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            ret_buf    <= '0;
            last_grant <= ~PRIO_D;
        end else if (ret_take) begin
            ret_buf    <= m_ret_data;
            last_grant <= owner;
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            spurious_ret <= 1'b0;
        end else if (m_ret_valid && (state != WAIT)) begin
            spurious_ret <= 1'b1;
        end
    end

    // Acceptance is forwarded in the same cycle the bridge accepts.
    assign i_rd_rdy   = (state == REQ) && m_rd_rdy && !owner;
    assign d_rd_rdy   = (state == REQ) && m_rd_rdy &&  owner;

    assign i_ret_data = ret_buf;
    assign d_ret_data = ret_buf;

endmodule

// File: tb/tb_cache_rd_arbiter.sv
module tb_cache_rd_arbiter;

    localparam logic [127:0] DATA1 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic         i_rd_req = 1'b0;
    logic [31:0]  i_rd_addr = '0;
    logic         i_rd_rdy;
    logic         i_ret_valid;
    logic [127:0] i_ret_data;
    logic         d_rd_req = 1'b0;
    logic [31:0]  d_rd_addr = '0;
    logic         d_rd_rdy;
    logic         d_ret_valid;
    logic [127:0] d_ret_data;
    logic         m_rd_req;
    logic [31:0]  m_rd_addr;
    logic         m_rd_rdy = 1'b0;
    logic         m_ret_valid = 1'b0;
    logic [127:0] m_ret_data = '0;
    logic         busy;
    logic         spurious_ret;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;
    int last_resp_cyc = 0;

    cache_rd_arbiter #(
        .ADDR_W (32),
        .LINE_W (128),
        .PRIO_D (1'b1)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .i_rd_req     (i_rd_req),
        .i_rd_addr    (i_rd_addr),
        .i_rd_rdy     (i_rd_rdy),
        .i_ret_valid  (i_ret_valid),
        .i_ret_data   (i_ret_data),
        .d_rd_req     (d_rd_req),
        .d_rd_addr    (d_rd_addr),
        .d_rd_rdy     (d_rd_rdy),
        .d_ret_valid  (d_ret_valid),
        .d_ret_data   (d_ret_data),
        .m_rd_req     (m_rd_req),
        .m_rd_addr    (m_rd_addr),
        .m_rd_rdy     (m_rd_rdy),
        .m_ret_valid  (m_ret_valid),
        .m_ret_data   (m_ret_data),
        .busy         (busy),
        .spurious_ret (spurious_ret)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt = cyc_cnt + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; inputs are changed
    // there and outputs are sampled a further unit later.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        #1;
        chk({tag, "_m_rd_req"},  128'(m_rd_req),     128'd0);
        chk({tag, "_m_rd_addr"}, 128'(m_rd_addr),    128'd0);
        chk({tag, "_busy"},      128'(busy),         128'd0);
        chk({tag, "_i_rdy"},     128'(i_rd_rdy),     128'd0);
        chk({tag, "_d_rdy"},     128'(d_rd_rdy),     128'd0);
        chk({tag, "_i_ret_v"},   128'(i_ret_valid),  128'd0);
        chk({tag, "_d_ret_v"},   128'(d_ret_valid),  128'd0);
        chk({tag, "_i_data"},    i_ret_data,         128'd0);
        chk({tag, "_spur"},      128'(spurious_ret), 128'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        i_rd_req = 1'b0;
        d_rd_req = 1'b0;
        m_rd_rdy = 1'b0;
        m_ret_valid = 1'b0;
        nxt();
        nxt();
        chk_quiet("rst");
        resetn = 1'b0;
        nxt();
    endtask

    // Bridge model for one transaction. Expected owner/address come from the
    // caller; rdy_dly cycles of backpressure, ret_dly cycles in WAIT.
    task automatic serve(input logic exp_d, input logic [31:0] exp_addr,
                         input logic [127:0] data, input int rdy_dly,
                         input int ret_dly, input logic keep, input logic gap_chk);
        int w;
        w = 0;
        while (!m_rd_req && w < 30) begin
            nxt();
            w = w + 1;
        end
        if (!m_rd_req) begin
            chk("req_timeout", 128'd0, 128'd1);
            return;
        end
        for (int k = 0; k < rdy_dly; k++) begin
            #1;
            chk("bp_m_rd_req",  128'(m_rd_req),  128'd1);
            chk("bp_m_rd_addr", 128'(m_rd_addr), 128'(exp_addr));
            chk("bp_no_rdy",    128'(i_rd_rdy | d_rd_rdy), 128'd0);
            nxt();
        end
        m_rd_rdy = 1'b1;
        #1;
        chk("m_rd_addr", 128'(m_rd_addr), 128'(exp_addr));
        chk("i_rd_rdy",  128'(i_rd_rdy),  128'(!exp_d));
        chk("d_rd_rdy",  128'(d_rd_rdy),  128'(exp_d));
        chk("busy_req",  128'(busy),      128'd1);
        nxt();
        m_rd_rdy = 1'b0;
        if (exp_d) begin
            if (keep) d_rd_addr = d_rd_addr + 32'h40;
            else      d_rd_req = 1'b0;
        end else begin
            if (keep) i_rd_addr = i_rd_addr + 32'h40;
            else      i_rd_req = 1'b0;
        end
        for (int k = 0; k < ret_dly; k++) begin
            #1;
            chk("wait_m_rd_req", 128'(m_rd_req), 128'd0);
            chk("wait_no_ret",   128'(i_ret_valid | d_ret_valid), 128'd0);
            nxt();
        end
        m_ret_valid = 1'b1;
        m_ret_data = data;
        #1;
        chk("ret_lat", 128'(i_ret_valid | d_ret_valid), 128'd0);
        nxt();
        m_ret_valid = 1'b0;
        m_ret_data = '0;
        #1;
        chk("i_ret_valid", 128'(i_ret_valid), 128'(!exp_d));
        chk("d_ret_valid", 128'(d_ret_valid), 128'(exp_d));
        chk("i_ret_data",  i_ret_data, data);
        chk("d_ret_data",  d_ret_data, data);
        if (gap_chk) chk("gap_ge4", 128'((cyc_cnt - last_resp_cyc) >= 4), 128'd1);
        last_resp_cyc = cyc_cnt;
        nxt();
    endtask

    initial begin
        // Reset values
        do_reset();

        // Single icache miss: req t0, rdy t2, ret t5 -> i_ret_valid t6, idle t7
        i_rd_req = 1'b1;
        i_rd_addr = 32'h1FC0_0040;
        #1;
        chk("t0_m_rd_req", 128'(m_rd_req), 128'd0);
        nxt();
        serve(1'b0, 32'h1FC0_0040, DATA1, 1, 2, 1'b0, 1'b0);
        #1;
        chk("t7_busy", 128'(busy), 128'd0);
        chk("t7_i_ret_valid", 128'(i_ret_valid), 128'd0);

        // Contention from reset: D,I,D,I... for 8 transactions
        do_reset();
        i_rd_addr = 32'h1000_0000;
        d_rd_addr = 32'h2000_0000;
        i_rd_req = 1'b1;
        d_rd_req = 1'b1;
        for (int n = 0; n < 8; n++) begin
            if (n % 2 == 0) serve(1'b1, d_rd_addr, 128'(n + 32'hD00), 0, 0, 1'b1, n > 0);
            else            serve(1'b0, i_rd_addr, 128'(n + 32'hA00), 0, 0, 1'b1, n > 0);
        end

        // Backpressure: 10 cycles with m_rd_rdy low
        do_reset();
        d_rd_req = 1'b1;
        d_rd_addr = 32'h0000_BEC0;
        serve(1'b1, 32'h0000_BEC0, ~DATA1, 10, 1, 1'b0, 1'b0);

        // Request dropped before rdy still completes to the latched owner
        i_rd_req = 1'b1;
        i_rd_addr = 32'h0000_7700;
        nxt();
        i_rd_req = 1'b0;
        serve(1'b0, 32'h0000_7700, DATA1 ^ 128'hFF, 0, 0, 1'b0, 1'b0);

        // Spurious return in IDLE
        m_ret_valid = 1'b1;
        m_ret_data = DATA1;
        nxt();
        m_ret_valid = 1'b0;
        #1;
        chk("spur_set",   128'(spurious_ret), 128'd1);
        chk("spur_busy",  128'(busy),         128'd0);
        chk("spur_ret_v", 128'(i_ret_valid | d_ret_valid), 128'd0);
        nxt();
        nxt();
        #1;
        chk("spur_sticky", 128'(spurious_ret), 128'd1);
        chk("spur_idle",   128'(m_rd_req | busy), 128'd0);

        // Reset while in WAIT
        i_rd_req = 1'b1;
        i_rd_addr = 32'h0000_1240;
        nxt();
        m_rd_rdy = 1'b1;
        nxt();
        m_rd_rdy = 1'b0;
        i_rd_req = 1'b0;
        #1;
        chk("pre_rst_busy", 128'(busy), 128'd1);
        resetn = 1'b1;
        chk_quiet("async_rst");
        nxt();
        resetn = 1'b0;
        nxt();
        m_ret_valid = 1'b1;
        m_ret_data = DATA1;
        nxt();
        m_ret_valid = 1'b0;
        #1;
        chk("post_rst_spur", 128'(spurious_ret), 128'd1);
        chk("post_rst_ret_v", 128'(i_ret_valid | d_ret_valid), 128'd0);
        chk("post_rst_busy", 128'(busy), 128'd0);
        nxt();
        #1;
        chk("post_rst_ret_v2", 128'(i_ret_valid | d_ret_valid), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
